// File: rtl/dcm_bank_pkg.sv
// ---------------------------------------------------------------------------
// dcm_bank_pkg
//
// Shared definitions for the dcm_bank divided-clock bank.
//   SEL_W        width of a rate select value
//   MAX_SHIFT    largest shift a select can request (sel = 7)
//   ch_ev_e      per-cycle event class of one channel counter
//   sel_shift()  maps a rate select onto a left-shift amount
//   half_period() half-period length in reference cycles for (base, sel)
//
// Optional feature macro used by the files importing this package:
//   DCM_BANK_SYNC_EN  adds a bank-wide synchronous realign input
// ---------------------------------------------------------------------------
package dcm_bank_pkg;

    localparam int SEL_W     = 3;
    localparam int MAX_SHIFT = 7;

    // What a channel does on the coming clock edge.
    typedef enum logic [1:0] {
        EV_RUN   = 2'd0,    // count up, outputs hold
        EV_TERM  = 2'd1,    // last cycle of a half-period: toggle and restart
        EV_CLEAR = 2'd2     // disabled or realigned: counter and output cleared
    } ch_ev_e;

    // Each select step doubles the half-period.
    function automatic int unsigned sel_shift(input logic [SEL_W-1:0] sel);
        return {29'd0, sel};
    endfunction

    function automatic logic [63:0] half_period(input logic [63:0]      base,
                                                input logic [SEL_W-1:0] sel);
        return base << sel_shift(sel);
    endfunction

endpackage

// File: rtl/dcm_bank_ch.sv
// ---------------------------------------------------------------------------
// dcm_bank_ch
//
// One divided-clock channel: half-period counter, 50%-duty output toggle,
// active rate select and a single-entry pending select that is only
// committed on a half-period boundary so no runt pulse is ever produced.
//
// Ports
//   clk        reference clock, rising edge
//   rst        asynchronous active-high reset
//   i_en       run enable; low clears counter/output and commits pending sel
//   i_sync     (DCM_BANK_SYNC_EN only) realign: behaves like a one-cycle
//              disable of the channel
//   i_wr       write strobe already decoded for this channel
//   i_wr_sel   rate select carried by the write
//   o_clk_out  divided clock
//   o_tick     one-cycle pulse alongside each 0->1 of o_clk_out
//   o_sel      active rate select
//   o_pend     a written select is waiting for its boundary
//
// Configuration macro: DCM_BANK_SYNC_EN
// ---------------------------------------------------------------------------
module dcm_bank_ch
    import dcm_bank_pkg::*;
#(
    parameter int CNT_W    = 30,
    parameter int DIV_BASE = 5000000,
    parameter int RST_SEL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
`ifdef DCM_BANK_SYNC_EN
    input  logic             i_sync,
`endif
    input  logic             i_wr,
    input  logic [SEL_W-1:0] i_wr_sel,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_pend
);

    localparam logic [SEL_W-1:0] RST_SEL_V = SEL_W'(RST_SEL);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic [SEL_W-1:0] r_active;
    logic [SEL_W-1:0] r_pend_sel;
    logic             r_pend;

    logic [CNT_W-1:0] w_half_m1;
    logic             w_clear;
    ch_ev_e           w_ev;

    // Terminal count for the currently active select. Range is guaranteed
    // by the elaboration check in the top level.
    assign w_half_m1 = CNT_W'(half_period(64'(DIV_BASE), r_active) - 64'd1);

`ifdef DCM_BANK_SYNC_EN
    assign w_clear = ~i_en | i_sync;
`else
    assign w_clear = ~i_en;
`endif

    // Clear outranks the terminal count so a realign always wins.
    always_comb begin
        w_ev = EV_RUN;
        if (w_clear) begin
            w_ev = EV_CLEAR;
        end else if (r_cnt == w_half_m1) begin
            w_ev = EV_TERM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
            r_active   <= RST_SEL_V;
            r_pend_sel <= RST_SEL_V;
            r_pend     <= 1'b0;
        end else begin
            case (w_ev)
                EV_CLEAR: begin
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                    r_tick    <= 1'b0;
                    if (r_pend) begin
                        r_active <= r_pend_sel;
                    end
                end
                EV_TERM: begin
                    r_cnt     <= '0;
                    r_clk_out <= ~r_clk_out;
                    // Rising edge of the divided clock is when it was low.
                    r_tick    <= ~r_clk_out;
                    if (r_pend) begin
                        r_active <= r_pend_sel;
                    end
                end
                default: begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_tick <= 1'b0;
                end
            endcase

            // A write landing on a boundary is held for the next one: the
            // boundary commits the value pending before the write (read from
            // r_pend_sel above), the write itself refills the pending slot.
            if (i_wr) begin
                r_pend_sel <= i_wr_sel;
                r_pend     <= 1'b1;
            end else if (w_ev != EV_RUN) begin
                r_pend     <= 1'b0;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_sel     = r_active;
    assign o_pend    = r_pend;

endmodule

// File: rtl/dcm_bank.sv
// ---------------------------------------------------------------------------
// dcm_bank
//
// Bank of N_CH independent 50%-duty clock dividers. Each channel's
// half-period is DIV_BASE << sel reference cycles; sel is changed through a
// single write port and takes effect on the channel's next half-period
// boundary.
//
// Parameters
//   N_CH      number of channels (1..16)
//   CNT_W     half-period counter width
//   DIV_BASE  half-period in clk cycles for sel = 0
//   RST_SEL   select loaded into every channel at reset
//   WR_CH_W   width of i_wr_ch; may be widened beyond the minimum so that
//             out-of-range channel numbers can be presented
//
// Ports
//   clk         reference clock, rising edge
//   rst         asynchronous active-high reset
//   i_en        per-channel run enable
//   i_wr_en     single-cycle select write strobe
//   i_wr_ch     target channel of the write
//   i_wr_sel    requested rate select
//   i_sync      (DCM_BANK_SYNC_EN only) realign every channel
//   o_wr_err    one-cycle pulse after a write to a nonexistent channel
//   o_clk_out   divided clocks
//   o_tick      one-cycle pulse with each clk_out 0->1
//   o_prog_out  active select, channel i at [3i+2:3i]
//   o_pend_out  written select awaiting its boundary
//
// Configuration macro: DCM_BANK_SYNC_EN
// ---------------------------------------------------------------------------
module dcm_bank
    import dcm_bank_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 30,
    parameter int DIV_BASE = 5000000,
    parameter int RST_SEL  = 0,
    parameter int WR_CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       i_en,
    input  logic                  i_wr_en,
    input  logic [WR_CH_W-1:0]    i_wr_ch,
    input  logic [SEL_W-1:0]      i_wr_sel,
`ifdef DCM_BANK_SYNC_EN
    input  logic                  i_sync,
`endif
    output logic                  o_wr_err,
    output logic [N_CH-1:0]       o_clk_out,
    output logic [N_CH-1:0]       o_tick,
    output logic [SEL_W*N_CH-1:0] o_prog_out,
    output logic [N_CH-1:0]       o_pend_out
);

    // Longest half-period the counter must reach (sel = 7), minus one.
    localparam logic [63:0] MAX_HALF_M1 =
        half_period(64'(DIV_BASE), SEL_W'(MAX_SHIFT)) - 64'd1;

    generate
        if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
            $fatal(1, "dcm_bank: N_CH must be within 1..16");
        end
        if (DIV_BASE < 1) begin : g_bad_base
            $fatal(1, "dcm_bank: DIV_BASE must be at least 1");
        end
        if (CNT_W < 64 && (MAX_HALF_M1 >> CNT_W) != 64'd0) begin : g_bad_cnt_w
            $fatal(1, "dcm_bank: (DIV_BASE << 7) - 1 does not fit in CNT_W bits");
        end
        if (N_CH > 1 && WR_CH_W < $clog2(N_CH)) begin : g_bad_wr_ch_w
            $fatal(1, "dcm_bank: WR_CH_W too narrow to address every channel");
        end
    endgenerate

    // Write decode. Comparing at 32 bits keeps the decode independent of
    // how much wider than necessary i_wr_ch has been made.
    logic [31:0]     w_wr_ch_ext;
    logic            w_wr_oor;
    logic [N_CH-1:0] w_wr_hit;
    logic            r_wr_err;

    assign w_wr_ch_ext = 32'(i_wr_ch);
    assign w_wr_oor    = i_wr_en && (w_wr_ch_ext >= 32'(N_CH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_oor;
        end
    end

    assign o_wr_err = r_wr_err;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign w_wr_hit[gi] = i_wr_en && (w_wr_ch_ext == 32'(gi));

            dcm_bank_ch #(
                .CNT_W    (CNT_W),
                .DIV_BASE (DIV_BASE),
                .RST_SEL  (RST_SEL)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .i_en      (i_en[gi]),
`ifdef DCM_BANK_SYNC_EN
                .i_sync    (i_sync),
`endif
                .i_wr      (w_wr_hit[gi]),
                .i_wr_sel  (i_wr_sel),
                .o_clk_out (o_clk_out[gi]),
                .o_tick    (o_tick[gi]),
                .o_sel     (o_prog_out[SEL_W*gi +: SEL_W]),
                .o_pend    (o_pend_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dcm_bank.sv
// ---------------------------------------------------------------------------
// tb_dcm_bank
//
// Directed bench for dcm_bank with N_CH=4, DIV_BASE=2, RST_SEL=0 and a 3-bit
// write channel field. A per-cycle vector table covers steady running, a
// mid half-period select change, a write on a terminal cycle and an
// out-of-range write; hand-written sequences cover disable/re-enable,
// asynchronous reset with pending writes, back-to-back pending writes and
// (when DCM_BANK_SYNC_EN is defined) the realign input.
// ---------------------------------------------------------------------------
module tb_dcm_bank;

    localparam int N_CH  = 4;
    localparam int NROWS = 22;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [2:0]  wr_sel;
`ifdef DCM_BANK_SYNC_EN
    logic        sync;
`endif
    logic        wr_err;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [11:0] prog_out;
    logic [3:0]  pend_out;

    int n_vec = 0;
    int n_err = 0;

    dcm_bank #(
        .N_CH     (N_CH),
        .CNT_W    (8),
        .DIV_BASE (2),
        .RST_SEL  (0),
        .WR_CH_W  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_wr_en    (wr_en),
        .i_wr_ch    (wr_ch),
        .i_wr_sel   (wr_sel),
`ifdef DCM_BANK_SYNC_EN
        .i_sync     (sync),
`endif
        .o_wr_err   (wr_err),
        .o_clk_out  (clk_out),
        .o_tick     (tick),
        .o_prog_out (prog_out),
        .o_pend_out (pend_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic        wr_en;
        logic [2:0]  wr_ch;
        logic [2:0]  wr_sel;
        logic [3:0]  exp_clk;
        logic [3:0]  exp_tick;
        logic [11:0] exp_prog;
        logic [3:0]  exp_pend;
        logic        exp_err;
    } vec_t;

    vec_t tbl [NROWS];

    function automatic vec_t mk(input logic wr, input logic [2:0] ch, input logic [2:0] sel,
                                input logic [3:0] c, input logic [3:0] t,
                                input logic [11:0] p, input logic [3:0] pd, input logic e);
        vec_t v;
        v.en = 4'hF; v.wr_en = wr; v.wr_ch = ch; v.wr_sel = sel;
        v.exp_clk = c; v.exp_tick = t; v.exp_prog = p; v.exp_pend = pd; v.exp_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one reference cycle; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Channel sequence, all channels enabled from row 0 at sel 0 (half = 2):
        // ch1 gets sel 2 at row 8 (committed row 9, half = 8), ch3 gets sel 1
        // on its terminal row 11 (committed row 13, half = 4), row 14 writes
        // nonexistent channel 5.
        //            wr  ch sel   clk   tick  prog     pend  err
        tbl[0]  = mk(0, 0, 0, 4'h0, 4'h0, 12'h000, 4'h0, 0);
        tbl[1]  = mk(0, 0, 0, 4'hF, 4'hF, 12'h000, 4'h0, 0);
        tbl[2]  = mk(0, 0, 0, 4'hF, 4'h0, 12'h000, 4'h0, 0);
        tbl[3]  = mk(0, 0, 0, 4'h0, 4'h0, 12'h000, 4'h0, 0);
        tbl[4]  = mk(0, 0, 0, 4'h0, 4'h0, 12'h000, 4'h0, 0);
        tbl[5]  = mk(0, 0, 0, 4'hF, 4'hF, 12'h000, 4'h0, 0);
        tbl[6]  = mk(0, 0, 0, 4'hF, 4'h0, 12'h000, 4'h0, 0);
        tbl[7]  = mk(0, 0, 0, 4'h0, 4'h0, 12'h000, 4'h0, 0);
        tbl[8]  = mk(1, 1, 2, 4'h0, 4'h0, 12'h000, 4'h2, 0);
        tbl[9]  = mk(0, 0, 0, 4'hF, 4'hF, 12'h010, 4'h0, 0);
        tbl[10] = mk(0, 0, 0, 4'hF, 4'h0, 12'h010, 4'h0, 0);
        tbl[11] = mk(1, 3, 1, 4'h2, 4'h0, 12'h010, 4'h8, 0);
        tbl[12] = mk(0, 0, 0, 4'h2, 4'h0, 12'h010, 4'h8, 0);
        tbl[13] = mk(0, 0, 0, 4'hF, 4'hD, 12'h210, 4'h0, 0);
        tbl[14] = mk(1, 5, 6, 4'hF, 4'h0, 12'h210, 4'h0, 1);
        tbl[15] = mk(0, 0, 0, 4'hA, 4'h0, 12'h210, 4'h0, 0);
        tbl[16] = mk(0, 0, 0, 4'hA, 4'h0, 12'h210, 4'h0, 0);
        tbl[17] = mk(0, 0, 0, 4'h5, 4'h5, 12'h210, 4'h0, 0);
        tbl[18] = mk(0, 0, 0, 4'h5, 4'h0, 12'h210, 4'h0, 0);
        tbl[19] = mk(0, 0, 0, 4'h0, 4'h0, 12'h210, 4'h0, 0);
        tbl[20] = mk(0, 0, 0, 4'h0, 4'h0, 12'h210, 4'h0, 0);
        tbl[21] = mk(0, 0, 0, 4'hD, 4'hD, 12'h210, 4'h0, 0);

        rst = 1'b1; en = 4'h0; wr_en = 1'b0; wr_ch = 3'd0; wr_sel = 3'd0;
`ifdef DCM_BANK_SYNC_EN
        sync = 1'b0;
`endif

        // Reset state
        repeat (3) step();
        chk("rst_clk_out",  32'(clk_out),  32'h0);
        chk("rst_tick",     32'(tick),     32'h0);
        chk("rst_prog_out", 32'(prog_out), 32'h0);
        chk("rst_pend_out", 32'(pend_out), 32'h0);
        chk("rst_wr_err",   32'(wr_err),   32'h0);
        rst = 1'b0;
        step();
        chk("idle_clk_out", 32'(clk_out), 32'h0);

        // Vector table
        for (int r = 0; r < NROWS; r++) begin
            en = tbl[r].en; wr_en = tbl[r].wr_en; wr_ch = tbl[r].wr_ch; wr_sel = tbl[r].wr_sel;
            step();
            $display("row %0d: wr=%0d ch=%0d sel=%0d -> clk=%h tick=%h prog=%h pend=%h err=%0d",
                     r, wr_en, wr_ch, wr_sel, clk_out, tick, prog_out, pend_out, wr_err);
            chk($sformatf("row%0d_clk_out", r),  32'(clk_out),  32'(tbl[r].exp_clk));
            chk($sformatf("row%0d_tick", r),     32'(tick),     32'(tbl[r].exp_tick));
            chk($sformatf("row%0d_prog_out", r), 32'(prog_out), 32'(tbl[r].exp_prog));
            chk($sformatf("row%0d_pend_out", r), 32'(pend_out), 32'(tbl[r].exp_pend));
            chk($sformatf("row%0d_wr_err", r),   32'(wr_err),   32'(tbl[r].exp_err));
        end
        wr_en = 1'b0;

        // Disable ch2 while its clock is high with sel 3 pending, then re-enable.
        wr_en = 1'b1; wr_ch = 3'd2; wr_sel = 3'd3;
        step();
        wr_en = 1'b0;
        $display("dis: write ch2 sel3 -> clk=%h pend=%h", clk_out, pend_out);
        chk("dis_pre_clk2", 32'(clk_out[2]), 32'h1);
        chk("dis_pre_pend", 32'(pend_out),   32'h4);
        en = 4'b1011;
        step();
        $display("dis: en=%h -> clk=%h prog=%h pend=%h", en, clk_out, prog_out, pend_out);
        chk("dis_clk2",     32'(clk_out[2]), 32'h0);
        chk("dis_prog_out", 32'(prog_out),   32'h2D0);
        chk("dis_pend_out", 32'(pend_out),   32'h0);
        repeat (2) step();
        chk("dis_hold_clk2", 32'(clk_out[2]), 32'h0);
        en = 4'hF;
        for (int k = 1; k <= 16; k++) begin
            step();
            $display("reen cycle %0d: clk2=%0d tick2=%0d", k, clk_out[2], tick[2]);
            if (k < 16) begin
                chk($sformatf("reen_c%0d_clk2", k), 32'(clk_out[2] | tick[2]), 32'h0);
            end else begin
                chk("reen_rise_clk2",  32'(clk_out[2]), 32'h1);
                chk("reen_rise_tick2", 32'(tick[2]),    32'h1);
            end
        end

        // Asynchronous reset mid-run with a pending write outstanding.
        wr_en = 1'b1; wr_ch = 3'd0; wr_sel = 3'd5;
        step();
        wr_en = 1'b0;
        chk("prerst_pend0", 32'(pend_out[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        $display("async rst -> clk=%h tick=%h prog=%h pend=%h err=%0d",
                 clk_out, tick, prog_out, pend_out, wr_err);
        chk("arst_clk_out",  32'(clk_out),  32'h0);
        chk("arst_tick",     32'(tick),     32'h0);
        chk("arst_prog_out", 32'(prog_out), 32'h0);
        chk("arst_pend_out", 32'(pend_out), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rel_e1_clk_out", 32'(clk_out), 32'h0);
        step();
        $display("post-rst edge 2 -> clk=%h tick=%h prog=%h", clk_out, tick, prog_out);
        chk("rel_e2_clk_out",  32'(clk_out),  32'hF);
        chk("rel_e2_tick",     32'(tick),     32'hF);
        chk("rel_e2_prog_out", 32'(prog_out), 32'h0);

        // Two writes to ch0: the second lands on the terminal that commits the first.
        wr_en = 1'b1; wr_ch = 3'd0; wr_sel = 3'd1;
        step();
        chk("pp_e3_pend", 32'(pend_out), 32'h1);
        chk("pp_e3_prog", 32'(prog_out), 32'h0);
        wr_sel = 3'd2;
        step();
        wr_en = 1'b0;
        $display("pp: write ch0 sel2 on terminal -> clk=%h prog=%h pend=%h", clk_out, prog_out, pend_out);
        chk("pp_e4_prog", 32'(prog_out),   32'h1);
        chk("pp_e4_pend", 32'(pend_out),   32'h1);
        chk("pp_e4_clk0", 32'(clk_out[0]), 32'h0);
        repeat (3) step();
        chk("pp_e7_clk0", 32'(clk_out[0]), 32'h0);
        step();
        $display("pp: edge 8 -> clk=%h tick=%h prog=%h pend=%h", clk_out, tick, prog_out, pend_out);
        chk("pp_e8_clk0", 32'(clk_out[0]), 32'h1);
        chk("pp_e8_tick0", 32'(tick[0]),   32'h1);
        chk("pp_e8_prog", 32'(prog_out),   32'h2);
        chk("pp_e8_pend", 32'(pend_out),   32'h0);

`ifdef DCM_BANK_SYNC_EN
        // Realign: everything low next cycle, sel-0 channels rise together after 2.
        sync = 1'b1;
        step();
        sync = 1'b0;
        $display("sync -> clk=%h tick=%h", clk_out, tick);
        chk("sync_clk_out", 32'(clk_out), 32'h0);
        chk("sync_tick",    32'(tick),    32'h0);
        step();
        step();
        chk("sync_rise_clk", 32'(clk_out[3:1]), 32'h7);
        chk("sync_rise_tick", 32'(tick[3:1]),   32'h7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
